// File: rtl/cvae_pkg.sv
// cvae_pkg: constants and writeback state enum shared by the CVAE core, state_writeback and benches.
package cvae_pkg;
    localparam int STATE_WORDS = 13;
    localparam int MAX_STEPS   = 59;
    localparam int BASE_ADDR   = 13;
    localparam int WORD_W      = 4;
    localparam int STEP_W      = 6;
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} wb_state_t;
endpackage

// File: rtl/wb_addr_gen.sv
// wb_addr_gen: word/step counters, state SRAM address and wrap/terminal-count flags.
module wb_addr_gen
    import cvae_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  adv,
    input  logic                  init,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [STEP_W-1:0]     step,
    output logic                  word_last,
    output logic                  step_last
);
    logic [WORD_W-1:0] word;

    assign word_last = word == WORD_W'(STATE_WORDS - 1);
    assign step_last = step == STEP_W'(MAX_STEPS - 1);
    // The initial-state burst uses the word counter alone to cover addresses 0..12.
    assign addr = init ? ADDR_WIDTH'(word)
                       : ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(step) * ADDR_WIDTH'(STATE_WORDS) + ADDR_WIDTH'(word);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word <= '0;
            step <= '0;
        end else if (adv) begin
            word <= word_last ? '0 : word + WORD_W'(1);
            if (word_last && !init) step <= step + STEP_W'(1);
        end
    end
endmodule

// File: rtl/state_writeback.sv
// state_writeback: packs per-step CVAE state words into the state SRAM and tracks sequence length.
// Define STATE_WB_INIT_EN to write a 13-word initial-state burst from init_data after each start.
module state_writeback
    import cvae_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] init_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last_step,
    output logic                  sram_state_wea,
    output logic [ADDR_WIDTH-1:0] sram_state_addr,
    output logic [DATA_WIDTH-1:0] sram_state_wdata,
    output logic [STEP_W-1:0]     seq_lens,
    output logic                  finish
);
    wb_state_t state_q, state_d;
    logic acc, init_wr, word_last, step_last;
    logic [ADDR_WIDTH-1:0] addr;

`ifdef STATE_WB_INIT_EN
    localparam wb_state_t START_ST = INIT;
    assign init_wr = state_q == INIT && !start;
`else
    localparam wb_state_t START_ST = RUN;
    assign init_wr = 1'b0;
`endif

    assign in_ready = state_q == RUN;
    assign acc      = in_valid && in_ready && !start;
    assign finish   = state_q == DONE;

    wb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .adv       (acc || init_wr),
        .init      (state_q == INIT),
        .addr      (addr),
        .step      (seq_lens),
        .word_last (word_last),
        .step_last (step_last)
    );

    always_comb begin
        state_d = state_q;
        if (start) state_d = START_ST;
        else if (state_q == INIT && word_last) state_d = RUN;
        else if (acc && word_last && (in_last_step || step_last)) state_d = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            sram_state_wea   <= 1'b0;
            sram_state_addr  <= '0;
            sram_state_wdata <= '0;
        end else begin
            state_q        <= state_d;
            sram_state_wea <= acc || init_wr;
            if (acc || init_wr) begin
                sram_state_addr  <= addr;
                sram_state_wdata <= init_wr ? init_data : in_data;
            end
        end
    end
endmodule
